// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a data-bus wait controller.
// Holds the execute result and the bus response stable for the memory stage until the access retires.

package ex_mem_pkg;
   typedef struct packed {
      logic        valid;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
      logic [4:0]  rd;
      logic [63:0] aluout;
      logic [63:0] writedata;
   } execute_data_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

// state  | meaning
// S_IDLE | no access pending; register loads when not stalled
// S_WAIT | bus access outstanding; entry held, upstream stalled
// S_DONE | response captured; held until downstream accepts
module ex_mem_reg
   import ex_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE_in,
   input  logic          stall,
   input  logic          flush,
   input  dbus_resp_t    dresp,
   output execute_data_t dataE,
   output dbus_resp_t    dresp_m,
   output logic          mem_busy,
   output logic          timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] TC_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             load, squash, capture;
   logic             pending_flush_q;
   logic [63:0]      hold_q;
   logic [CNT_W-1:0] cnt_q;
   logic             waiting;
   logic             unused_addr_ok;

   // addr_ok carries no meaning here: completion is data_ok alone
   assign unused_addr_ok = dresp.addr_ok;

   function automatic logic is_mem(input execute_data_t d);
      return d.valid & (d.memread | d.memwrite | d.memtoreg);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      squash  = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               squash = 1'b1;
            end else if (!stall) begin
               load    = 1'b1;
               state_d = is_mem(dataE_in) ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            // the transaction must complete even if flushed; its data is dropped
            if (dresp.data_ok) begin
               if (pending_flush_q || flush) begin
                  squash  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (flush) begin
               squash  = 1'b1;
               state_d = S_IDLE;
            end else if (!stall) begin
               load    = 1'b1;
               state_d = is_mem(dataE_in) ? S_WAIT : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       dataE       <= '0;
      else if (squash) dataE.valid <= 1'b0;
      else if (load)   dataE       <= dataE_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        hold_q <= '0;
      else if (capture) hold_q <= dresp.data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending_flush_q <= 1'b0;
      else       pending_flush_q <= (state_q == S_WAIT) && !dresp.data_ok
                                    && (pending_flush_q || flush);
   end

   assign waiting = (state_q == S_WAIT) && !dresp.data_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               cnt_q <= '0;
      else if (!waiting)       cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timeout_err <= 1'b0;
      else if ((TIMEOUT_CYCLES != 0) && waiting && (cnt_q == TC_LAST))
         timeout_err <= 1'b1;
   end

   assign mem_busy = (state_q == S_WAIT);

   always_comb begin
      dresp_m = '0;
      if (state_q == S_DONE) begin
         dresp_m.addr_ok = 1'b1;
         dresp_m.data_ok = 1'b1;
         dresp_m.data    = hold_q;
      end
   end

endmodule
